// File: rtl/pattern_checker_pkg.sv
// Shared types and constants for the memory-game pattern checker.
// Holds the FSM state encoding, symbol/level widths and the symbol fold helper.
package pattern_checker_pkg;

  localparam int SYMBOL_W    = 3;
  localparam int NUM_SYMBOLS = 5;
  localparam int LEVEL_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_CAPTURE,
    S_SHOW_ON,
    S_SHOW_OFF,
    S_WAIT_KEY,
    S_PASS,
    S_FAIL
  } state_t;

  // The generator can emit 5..7; those alias back onto 0..2.
  function automatic logic [SYMBOL_W-1:0] fold_symbol(input logic [SYMBOL_W-1:0] i_value);
    return (i_value >= SYMBOL_W'(NUM_SYMBOLS)) ? i_value - SYMBOL_W'(NUM_SYMBOLS) : i_value;
  endfunction

endpackage

// File: rtl/pattern_timer.sv
// Loadable down-counter with a terminal-count flag.
// o_done is high whenever the count sits at zero; a load takes priority over counting.
module pattern_timer #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/pattern_checker.sv
// Memory-game sequence checker: grows a symbol sequence, plays it back, then checks key presses.
// Optional key-wait timeout is compiled in with the PATTERN_TIMEOUT_EN macro.
//
// state      | meaning
// S_IDLE     | waiting for i_seq_start
// S_FETCH    | pulse o_rand_en to advance the generator
// S_CAPTURE  | store folded rand value at mem[level-1]
// S_SHOW_ON  | display mem[idx] for SHOW_CYCLES
// S_SHOW_OFF | blank gap for SHOW_CYCLES, then next symbol or key wait
// S_WAIT_KEY | compare each key press against mem[idx]
// S_PASS     | round matched; level up or flag the win
// S_FAIL     | mismatch or timeout; remember failure for the next start
module pattern_checker
  import pattern_checker_pkg::*;
#(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 25_000_000,
  parameter int TIMEOUT_CYCLES = 250_000_000
) (
  input  logic                i_seq_clock,
  input  logic                i_seq_reset,
  input  logic                i_seq_start,
  input  logic [SYMBOL_W-1:0] i_rand_value,
  output logic                o_rand_en,
  output logic                o_show_valid,
  output logic [SYMBOL_W-1:0] o_show_symbol,
  input  logic                i_key_valid,
  input  logic [SYMBOL_W-1:0] i_key_symbol,
  output logic                o_busy,
  output logic                o_round_pass,
  output logic                o_round_fail,
  output logic                o_game_won,
  output logic [LEVEL_W-1:0]  o_level
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
`ifdef PATTERN_TIMEOUT_EN
  localparam int TMR_MAX = (TIMEOUT_CYCLES > SHOW_CYCLES) ? TIMEOUT_CYCLES : SHOW_CYCLES;
`else
  localparam int TMR_MAX = SHOW_CYCLES;
`endif
  localparam int TMR_W = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SHOW_LOAD = TMR_W'(SHOW_CYCLES - 1);
`ifdef PATTERN_TIMEOUT_EN
  localparam logic [TMR_W-1:0] TO_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);
`endif

  state_t              r_state;
  logic [SYMBOL_W-1:0] r_mem [MAX_LEN];
  logic [IDX_W-1:0]    r_idx;
  logic [LEVEL_W-1:0]  r_level;
  logic                r_won;
  logic                r_failed;

  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic                w_tmr_done;
  logic [IDX_W-1:0]    w_top_idx;
  logic                w_last;
  logic [SYMBOL_W-1:0] w_cur_sym;

  assign w_top_idx = IDX_W'(r_level - LEVEL_W'(1));
  assign w_last    = (r_idx == w_top_idx);
  assign w_cur_sym = r_mem[r_idx];

  // One timer serves both playback phases and the key wait; they never overlap.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = SHOW_LOAD;
    case (r_state)
      S_CAPTURE: w_tmr_load = 1'b1;
      S_SHOW_ON: w_tmr_load = w_tmr_done;
      S_SHOW_OFF: begin
        w_tmr_load = w_tmr_done;
`ifdef PATTERN_TIMEOUT_EN
        if (w_last) w_tmr_val = TO_LOAD;
`endif
      end
`ifdef PATTERN_TIMEOUT_EN
      S_WAIT_KEY: begin
        w_tmr_load = i_key_valid;
        w_tmr_val  = TO_LOAD;
      end
`endif
      default: ;
    endcase
  end

  pattern_timer #(.W(TMR_W)) u_timer (
    .i_clk      (i_seq_clock),
    .i_rst      (i_seq_reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  always_ff @(posedge i_seq_clock) begin
    if (i_seq_reset) begin
      r_state  <= S_IDLE;
      r_level  <= LEVEL_W'(1);
      r_idx    <= '0;
      r_won    <= 1'b0;
      r_failed <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_seq_start) begin
            r_state <= S_FETCH;
            if (r_failed || r_won) begin
              r_level  <= LEVEL_W'(1);
              r_won    <= 1'b0;
              r_failed <= 1'b0;
            end
          end
        end
        S_FETCH: r_state <= S_CAPTURE;
        S_CAPTURE: begin
          r_idx   <= '0;
          r_state <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (w_tmr_done) r_state <= S_SHOW_OFF;
        end
        S_SHOW_OFF: begin
          if (w_tmr_done) begin
            if (w_last) begin
              r_idx   <= '0;
              r_state <= S_WAIT_KEY;
            end else begin
              r_idx   <= r_idx + IDX_W'(1);
              r_state <= S_SHOW_ON;
            end
          end
        end
        S_WAIT_KEY: begin
          if (i_key_valid) begin
            if (i_key_symbol != w_cur_sym) r_state <= S_FAIL;
            else if (w_last)               r_state <= S_PASS;
            else                           r_idx   <= r_idx + IDX_W'(1);
          end
`ifdef PATTERN_TIMEOUT_EN
          else if (w_tmr_done) begin
            r_state <= S_FAIL;
          end
`endif
        end
        S_PASS: begin
          if (r_level == LEVEL_W'(MAX_LEN)) r_won   <= 1'b1;
          else                              r_level <= r_level + LEVEL_W'(1);
          r_state <= S_IDLE;
        end
        S_FAIL: begin
          r_failed <= 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Memory is not reset; every slot is written before it is first read.
  always_ff @(posedge i_seq_clock) begin
    if (r_state == S_CAPTURE) r_mem[w_top_idx] <= fold_symbol(i_rand_value);
  end

  assign o_rand_en     = (r_state == S_FETCH);
  assign o_show_valid  = (r_state == S_SHOW_ON);
  assign o_show_symbol = o_show_valid ? w_cur_sym : '0;
  assign o_busy        = (r_state != S_IDLE);
  assign o_round_pass  = (r_state == S_PASS);
  assign o_round_fail  = (r_state == S_FAIL);
  assign o_game_won    = r_won;
  assign o_level       = r_level;

endmodule
